axi_rd_responder: RTL and testbench

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

---
 rtl/axi_rd_responder.sv | 179 +++++++++++++++++
 tb/tb_axi_rd_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// ---------------------------------------------------------------------------
// axi_rd_responder
//
// AXI-style read-burst responder backed by an internal 2^ADDR_WIDTH x 32-bit
// memory. It accepts one read address at a time, waits FIRST_DELAY idle
// cycles, then streams arlen+1 beats of consecutive words. The word index
// wraps to 0 at the end of memory. A separate preload port writes the memory
// in any state. Reset does not touch the memory contents.
//
// Ports
//   clk      in   1           single clock, rising edge
//   rst      in   1           synchronous reset, active low
//   araddr   in   32          byte address of the first word of the burst
//   arlen    in   8           burst length minus one (1..256 beats)
//   arvalid  in   1           read-address valid
//   arready  out  1           read-address ready (IDLE and out of reset)
//   rdata    out  32          registered read data
//   rlast    out  1           final beat of the burst
//   rvalid   out  1           read-data valid
//   rready   in   1           read-data ready from the initiator
//   wr_en    in   1           preload write enable
//   wr_addr  in   ADDR_WIDTH  preload word index
//   wr_data  in   32          preload data
// ---------------------------------------------------------------------------
module axi_rd_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int FIRST_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           araddr,
    input  logic [7:0]            arlen,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [31:0]           wr_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] BURST = 2'd2;

    localparam logic [3:0]            DELAY_INIT = 4'(FIRST_DELAY);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE    = ADDR_WIDTH'(1);

    logic [31:0]           mem [DEPTH];

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_q, beat_d;
    logic [3:0]            dly_q, dly_d;
    logic [31:0]           rdata_q, rdata_d;

    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_idx;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  unused_araddr_bits;

    // Byte-offset bits and anything above the memory size play no part in
    // addressing; they are folded into a deliberately unused signal.
    assign ar_idx             = araddr[ADDR_WIDTH+1:2];
    assign unused_araddr_bits = ^{araddr[31:ADDR_WIDTH+2], araddr[1:0]};

    // arready is gated by rst so the initiator never sees a handshake
    // opportunity while reset is being held.
    assign arready = (state_q == IDLE) && rst;
    assign rvalid  = (state_q == BURST);
    assign rlast   = rvalid && (beat_q == len_q);
    assign rdata   = rdata_q;

    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // Next-state logic. Whenever the FSM is about to present a new beat
    // (entering BURST or advancing after an accepted non-last beat) it
    // raises load_en so rdata is refilled on the same edge, keeping rdata
    // valid from the very first cycle rvalid is high.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        beat_d   = beat_q;
        dly_d    = dly_q;
        load_en  = 1'b0;
        load_idx = idx_q;

        case (state_q)
            IDLE: begin
                if (ar_hs) begin
                    idx_d  = ar_idx;
                    len_d  = arlen;
                    beat_d = '0;
                    if (FIRST_DELAY == 0) begin
                        state_d  = BURST;
                        load_en  = 1'b1;
                        load_idx = ar_idx;
                    end else begin
                        state_d = WAIT;
                        dly_d   = DELAY_INIT;
                    end
                end
            end

            WAIT: begin
                if (dly_q <= 4'd1) begin
                    state_d  = BURST;
                    dly_d    = '0;
                    load_en  = 1'b1;
                    load_idx = idx_q;
                end else begin
                    dly_d = dly_q - 4'd1;
                end
            end

            BURST: begin
                if (r_hs) begin
                    if (rlast) begin
                        state_d = IDLE;
                    end else begin
                        beat_d   = beat_q + 8'd1;
                        idx_d    = idx_q + IDX_ONE;
                        load_en  = 1'b1;
                        load_idx = idx_q + IDX_ONE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The memory is read with the pre-edge contents, so a preload write to
    // the same word on the same edge leaves the old value in rdata.
    always_comb begin
        rdata_d = rdata_q;
        if (load_en) begin
            rdata_d = mem[load_idx];
        end
    end

    // Control and data registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            dly_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            dly_q   <= dly_d;
            rdata_q <= rdata_d;
        end
    end

    // Preload port; no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_axi_rd_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_responder
//
// Self-checking bench for axi_rd_responder. Two instances share clock, reset
// and the preload port: dut uses FIRST_DELAY=2, dut0 uses FIRST_DELAY=0.
// A reference memory array mirrors every preload write; expected bursts are
// computed from it as a list of words starting at (araddr/4) mod 1024.
// ---------------------------------------------------------------------------
module tb_axi_rd_responder;

    localparam int FIRST_DELAY = 2;
    localparam int MEM_WORDS   = 1024;

    typedef struct {
        logic [31:0] araddr;
        logic [7:0]  arlen;
        int          mode;
        logic [31:0] expFirst;
        logic [31:0] expLast;
        int          beats;
    } burst_vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] araddr0;
    logic [7:0]  arlen0;
    logic        arvalid0;
    logic        arready0;
    logic [31:0] rdata0;
    logic        rlast0;
    logic        rvalid0;
    logic        rready0;

    logic [31:0] refMem [MEM_WORDS];

    int assertCount = 0;
    int failCount   = 0;

    axi_rd_responder #(.ADDR_WIDTH(10), .FIRST_DELAY(FIRST_DELAY)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    axi_rd_responder #(.ADDR_WIDTH(10), .FIRST_DELAY(0)) dut0 (
        .clk(clk), .rst(rst),
        .araddr(araddr0), .arlen(arlen0), .arvalid(arvalid0), .arready(arready0),
        .rdata(rdata0), .rlast(rlast0), .rvalid(rvalid0), .rready(rready0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single comparison, counted and reported on mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Preload one word in both the DUT memories and the reference memory.
    task automatic writeWord(input int addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = 10'(addr);
        wr_data = data;
        refMem[addr] = data;
        step();
        wr_en = 1'b0;
    endtask

    // Run one full burst on dut: handshake, latency check, beat-by-beat data
    // check against the reference list, and return-to-idle check.
    // mode 0: rready always 1; mode 1: rready 1,0,0 repeating; mode 2: random.
    task automatic applyStimulus(input burst_vec_t v);
        logic [31:0] expq[$];
        int          base;
        int          cyc;
        int          toggle;
        int          accepted;
        logic [31:0] firstSeen;
        logic [31:0] lastSeen;

        base = int'((v.araddr >> 2) % MEM_WORDS);
        expq = {};
        for (int i = 0; i <= int'(v.arlen); i++) begin
            expq.push_back(refMem[(base + i) % MEM_WORDS]);
        end

        araddr  = v.araddr;
        arlen   = v.arlen;
        arvalid = 1'b1;
        rready  = 1'b0;
        cyc = 0;
        while (!arready && cyc < 20) begin
            step();
            cyc++;
        end
        checkOutput("arready_before_handshake", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;

        for (int k = 1; k <= FIRST_DELAY; k++) begin
            checkOutput("rvalid_during_delay", 32'(rvalid), 32'd0);
            checkOutput("arready_during_delay", 32'(arready), 32'd0);
            step();
        end
        checkOutput("rvalid_first_latency", 32'(rvalid), 32'd1);

        cyc       = 0;
        toggle    = 0;
        accepted  = 0;
        firstSeen = '0;
        lastSeen  = '0;
        while (expq.size() > 0 && cyc < 2000) begin
            checkOutput("rvalid_in_burst", 32'(rvalid), 32'd1);
            checkOutput("rdata_beat", rdata, expq[0]);
            checkOutput("rlast_beat", 32'(rlast), 32'(expq.size() == 1));
            checkOutput("arready_in_burst", 32'(arready), 32'd0);
            case (v.mode)
                0:       rready = 1'b1;
                1:       rready = ((toggle % 3) == 0);
                default: rready = 1'($urandom_range(0, 1));
            endcase
            toggle++;
            if (rready) begin
                if (accepted == 0) firstSeen = rdata;
                lastSeen = rdata;
                void'(expq.pop_front());
                accepted++;
            end
            step();
            cyc++;
        end
        rready = 1'b0;

        checkOutput("beat_count", 32'(accepted), 32'(v.beats));
        checkOutput("first_data", firstSeen, v.expFirst);
        checkOutput("last_data", lastSeen, v.expLast);
        checkOutput("rvalid_after_last", 32'(rvalid), 32'd0);
        checkOutput("arready_after_last", 32'(arready), 32'd1);
    endtask

    burst_vec_t vecs [7];
    burst_vec_t rv;

    // Main test sequence.
    initial begin
        rst      = 1'b0;
        araddr   = '0;
        arlen    = '0;
        arvalid  = 1'b0;
        rready   = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        araddr0  = '0;
        arlen0   = '0;
        arvalid0 = 1'b0;
        rready0  = 1'b1;

        // Reset state.
        step();
        step();
        checkOutput("reset_arready", 32'(arready), 32'd0);
        checkOutput("reset_rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset_rlast", 32'(rlast), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_arready0", 32'(arready0), 32'd0);
        rst = 1'b1;
        step();
        checkOutput("post_reset_arready", 32'(arready), 32'd1);
        checkOutput("post_reset_rvalid", 32'(rvalid), 32'd0);

        // Preload: mem[8..15] = 0x100..0x107, all others 0xC0DE0000 | index.
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (i >= 8 && i < 16) writeWord(i, 32'h100 + 32'(i - 8));
            else                  writeWord(i, 32'hC0DE_0000 | 32'(i));
        end

        // Directed burst table with hand-computed first/last words.
        vecs[0] = '{32'h0000_0020, 8'd7,   0, 32'h0000_0100, 32'h0000_0107, 8};
        vecs[1] = '{32'h0000_0020, 8'd7,   1, 32'h0000_0100, 32'h0000_0107, 8};
        vecs[2] = '{32'h0000_0FF8, 8'd3,   0, 32'hC0DE_03FE, 32'hC0DE_0001, 4};
        vecs[3] = '{32'h0000_0023, 8'd0,   0, 32'h0000_0100, 32'h0000_0100, 1};
        vecs[4] = '{32'hABCD_E010, 8'd2,   2, 32'hC0DE_0004, 32'hC0DE_0006, 3};
        vecs[5] = '{32'h0000_0000, 8'd255, 2, 32'hC0DE_0000, 32'hC0DE_00FF, 256};
        vecs[6] = '{32'h0000_03FC, 8'd1,   1, 32'hC0DE_00FF, 32'hC0DE_0100, 2};
        for (int n = 0; n < 7; n++) begin
            applyStimulus(vecs[n]);
        end

        // Zero-delay instance: single beat in the cycle after the handshake.
        araddr0  = 32'h20;
        arlen0   = 8'd0;
        arvalid0 = 1'b1;
        checkOutput("fd0_arready_idle", 32'(arready0), 32'd1);
        step();
        arvalid0 = 1'b0;
        checkOutput("fd0_rvalid", 32'(rvalid0), 32'd1);
        checkOutput("fd0_rlast", 32'(rlast0), 32'd1);
        checkOutput("fd0_rdata", rdata0, 32'h100);
        checkOutput("fd0_arready_busy", 32'(arready0), 32'd0);
        step();
        checkOutput("fd0_rvalid_after", 32'(rvalid0), 32'd0);
        checkOutput("fd0_arready_after", 32'(arready0), 32'd1);

        // Reset asserted while the third beat is presented.
        araddr  = 32'h20;
        arlen   = 8'd7;
        arvalid = 1'b1;
        rready  = 1'b1;
        step();
        arvalid = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checkOutput("midrst_third_beat", rdata, 32'h102);
        rst = 1'b0;
        step();
        checkOutput("midrst_rvalid", 32'(rvalid), 32'd0);
        checkOutput("midrst_arready", 32'(arready), 32'd0);
        checkOutput("midrst_rdata", rdata, 32'd0);
        rst = 1'b1;
        step();
        checkOutput("midrst_arready_back", 32'(arready), 32'd1);
        for (int k = 0; k < 8; k++) begin
            checkOutput("midrst_no_stale_beat", 32'(rvalid), 32'd0);
            step();
        end
        rready = 1'b0;

        // arvalid held through a burst with a new address: ignored until the
        // last beat is accepted, then served from its own address.
        araddr  = 32'h20;
        arlen   = 8'd3;
        arvalid = 1'b1;
        rready  = 1'b1;
        step();
        araddr = 32'h40;
        arlen  = 8'd0;
        for (int s = 1; s <= 6; s++) begin
            checkOutput("hold_arready_busy", 32'(arready), 32'd0);
            checkOutput("hold_rlast", 32'(rlast), 32'(s == 6));
            if (s >= 3) begin
                checkOutput("hold_rvalid", 32'(rvalid), 32'd1);
                checkOutput("hold_rdata", rdata, 32'h100 + 32'(s - 3));
            end
            step();
        end
        checkOutput("hold_arready_idle", 32'(arready), 32'd1);
        checkOutput("hold_rvalid_idle", 32'(rvalid), 32'd0);
        step();
        arvalid = 1'b0;
        step();
        step();
        checkOutput("second_rvalid", 32'(rvalid), 32'd1);
        checkOutput("second_rdata", rdata, 32'hC0DE_0010);
        checkOutput("second_rlast", 32'(rlast), 32'd1);
        step();
        checkOutput("second_done", 32'(rvalid), 32'd0);
        rready = 1'b0;

        // Preload write to the word being loaded on the same edge.
        araddr  = 32'h20;
        arlen   = 8'd3;
        arvalid = 1'b1;
        rready  = 1'b1;
        step();
        arvalid = 1'b0;
        step();
        step();
        checkOutput("rbw_beat0", rdata, 32'h100);
        wr_en   = 1'b1;
        wr_addr = 10'd9;
        wr_data = 32'hDEAD_BEEF;
        refMem[9] = 32'hDEAD_BEEF;
        step();
        wr_en = 1'b0;
        checkOutput("rbw_old_value", rdata, 32'h101);
        step();
        checkOutput("rbw_beat2", rdata, 32'h102);
        step();
        checkOutput("rbw_beat3", rdata, 32'h103);
        step();
        rready = 1'b0;
        rv = '{32'h0000_0024, 8'd0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1};
        applyStimulus(rv);
        writeWord(9, 32'h101);

        // Randomized bursts and preload writes checked against the model.
        for (int n = 0; n < 25; n++) begin
            int nw;
            int base;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) begin
                writeWord(int'($urandom_range(0, MEM_WORDS - 1)), $urandom);
            end
            rv.araddr = $urandom;
            rv.arlen  = 8'($urandom_range(0, 40));
            rv.mode   = 2;
            base      = int'((rv.araddr >> 2) % MEM_WORDS);
            rv.expFirst = refMem[base];
            rv.expLast  = refMem[(base + int'(rv.arlen)) % MEM_WORDS];
            rv.beats    = int'(rv.arlen) + 1;
            applyStimulus(rv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
